// File: rtl/frame_overlap_buffer.sv
// frame_overlap_buffer: circular-buffer framing stage for the MFCC front end.
// Samples are written into a 2^ADDR_W deep buffer. Overlapping frames of FRAME_LEN samples,
// advancing by HOP_LEN, are replayed as contiguous one-per-cycle bursts. A flush pulse emits
// a final zero-padded frame and then restarts framing from fresh samples.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   tvalid_stream     input sample strobe (at most one per cycle)
//   stream            input sample data
//   flush             one-cycle pulse requesting the final partial frame
//   tvalid_frame      output sample valid
//   frame_stream      output sample data
//   frame_first/last  mark sample 0 / FRAME_LEN-1 of each frame
//   frame_count       frames emitted since reset (wraps)
//   busy              frame emission in progress or flush pending
//   overflow          sticky: an input sample was dropped
module frame_overlap_buffer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned FRAME_LEN = 400,
  parameter int unsigned HOP_LEN   = 160,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tvalid_stream,
  input  logic [DATA_W-1:0] stream,
  input  logic              flush,
  output logic              tvalid_frame,
  output logic [DATA_W-1:0] frame_stream,
  output logic              frame_first,
  output logic              frame_last,
  output logic [15:0]       frame_count,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CW    = ADDR_W + 1;

  localparam logic [CW-1:0]     FrameLenC = CW'(FRAME_LEN);
  localparam logic [CW-1:0]     HopC      = CW'(HOP_LEN);
  localparam logic [CW-1:0]     DepthC    = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] HopA      = ADDR_W'(HOP_LEN);
  localparam logic [ADDR_W-1:0] LastIdx   = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {StIdle, StEmit, StFlushEmit} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       unseen_q, unseen_d;
  logic [CW-1:0]       flush_n_q, flush_n_d;
  logic                pending_q, pending_d;
  logic [15:0]         count_q, count_d;
  logic                overflow_q;
  logic                valid_q, first_q, last_q, zero_q;
  logic [DATA_W-1:0]   rd_data_q;

  logic                wr_en, drop;
  logic                rd_en, rd_zero, rd_first, rd_last;
  logic [ADDR_W-1:0]   rd_addr;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Writes are frozen during the flush frame so its content stays well defined.
  assign wr_en = tvalid_stream && (state_q != StFlushEmit) && (cnt_q != DepthC);
  assign drop  = tvalid_stream && (state_q != StFlushEmit) && (cnt_q == DepthC);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    base_d    = base_q;
    flush_n_d = flush_n_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q + ADDR_W'(wr_en);
    cnt_d     = cnt_q + CW'(wr_en);
    unseen_d  = unseen_q + CW'(wr_en);
    pending_d = pending_q | flush;
    rd_en     = 1'b0;
    rd_zero   = 1'b0;
    rd_first  = 1'b0;
    rd_last   = 1'b0;
    rd_addr   = base_q + idx_q;

    unique case (state_q)
      StIdle: begin
        // Backlog frames take priority over a pending flush.
        if (cnt_q >= FrameLenC) begin
          state_d  = StEmit;
          idx_d    = '0;
          unseen_d = CW'(wr_en);
        end else if (pending_q) begin
          if (unseen_q != '0) begin
            state_d   = StFlushEmit;
            idx_d     = '0;
            flush_n_d = cnt_q;  // cnt_q < FRAME_LEN here, so this is min(cnt, FRAME_LEN)
          end else begin
            // Nothing new to emit: restart framing, keeping a same-cycle write.
            base_d    = wr_ptr_q;
            cnt_d     = CW'(wr_en);
            unseen_d  = CW'(wr_en);
            pending_d = 1'b0;
          end
        end
      end
      StEmit: begin
        rd_en    = 1'b1;
        rd_first = (idx_q == '0);
        rd_last  = (idx_q == LastIdx);
        if (rd_last) begin
          state_d = StIdle;
          base_d  = base_q + HopA;
          cnt_d   = cnt_q + CW'(wr_en) - HopC;
          count_d = count_q + 16'd1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StFlushEmit: begin
        rd_en    = 1'b1;
        rd_zero  = ({1'b0, idx_q} >= flush_n_q);
        rd_first = (idx_q == '0);
        rd_last  = (idx_q == LastIdx);
        if (rd_last) begin
          state_d   = StIdle;
          base_d    = wr_ptr_q;
          cnt_d     = '0;
          unseen_d  = '0;
          pending_d = 1'b0;
          count_d   = count_q + 16'd1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      base_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      unseen_q   <= '0;
      flush_n_q  <= '0;
      pending_q  <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      unseen_q   <= unseen_d;
      flush_n_q  <= flush_n_d;
      pending_q  <= pending_d;
      count_q    <= count_d;
      overflow_q <= overflow_q | drop;
      valid_q    <= rd_en;
      first_q    <= rd_first;
      last_q     <= rd_last;
      zero_q     <= rd_zero;
    end
  end

  // Buffer storage and its registered read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= stream;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign tvalid_frame = valid_q;
  // Masking keeps the data output at zero out of frame and across reset.
  assign frame_stream = (valid_q && !zero_q) ? rd_data_q : '0;
  assign frame_first  = first_q;
  assign frame_last   = last_q;
  assign frame_count  = count_q;
  assign busy         = (state_q != StIdle) || pending_q || valid_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_frame_overlap_buffer.sv
module tb_frame_overlap_buffer;
  localparam int DW = 16;
  localparam int FL = 8;
  localparam int HL = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tvalid_stream = 1'b0;
  logic [DW-1:0] stream = '0;
  logic          flush = 1'b0;
  logic          tvalid_frame;
  logic [DW-1:0] frame_stream;
  logic          frame_first;
  logic          frame_last;
  logic [15:0]   frame_count;
  logic          busy;
  logic          overflow;

  always #5 clk = ~clk;

  frame_overlap_buffer #(
    .DATA_W   (DW),
    .FRAME_LEN(FL),
    .HOP_LEN  (HL),
    .ADDR_W   (AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tvalid_stream(tvalid_stream),
    .stream       (stream),
    .flush        (flush),
    .tvalid_frame (tvalid_frame),
    .frame_stream (frame_stream),
    .frame_first  (frame_first),
    .frame_last   (frame_last),
    .frame_count  (frame_count),
    .busy         (busy),
    .overflow     (overflow)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          first;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  int            ntests = 0;
  int            nfail = 0;
  bit            ovf_mode = 0;
  bit            gap_check = 0;
  bit            seen_ovf = 0;
  bit            have_prev = 0;
  int            cyc = 0;
  int            last_cyc = -1;
  logic [DW-1:0] fr[$];
  logic [DW-1:0] prev_fr[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ntests++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Output monitor: pops the scoreboard on every valid frame sample.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    cyc++;
    if (rst_n) begin
      if (ovf_mode) begin
        if (seen_ovf) chk("ovf_sticky", 32'(overflow), 32'd1);
        if (overflow === 1'b1) seen_ovf = 1;
        if (tvalid_frame) begin
          if (frame_first) fr.delete();
          fr.push_back(frame_stream);
          if (frame_last) begin
            chk("ovf_len", 32'(fr.size()), 32'(FL));
            ok = 1;
            for (int i = 1; i < fr.size(); i++) if (fr[i] <= fr[i-1]) ok = 0;
            chk("ovf_increasing", 32'(ok), 32'd1);
            chk("ovf_hop_start", 32'(fr[0]), have_prev ? 32'(prev_fr[HL]) : 32'd1);
            prev_fr = fr;
            have_prev = 1;
          end
        end
      end else if (tvalid_frame) begin
        ntests++;
        assert (exp_q.size() != 0) else begin
          nfail++;
          $error("FAIL unexpected_sample observed=%0h expected=none", frame_stream);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("frame_data", 32'(frame_stream), 32'(e.data));
          chk("frame_first", 32'(frame_first), 32'(e.first));
          chk("frame_last", 32'(frame_last), 32'(e.last));
          if (gap_check && frame_first && last_cyc >= 0) chk("frame_gap", 32'(cyc - last_cyc), 32'd2);
          if (frame_last) last_cyc = cyc;
        end
      end else if (exp_q.size() != 0 && !exp_q[0].first) begin
        chk("frame_contiguous", 32'(tvalid_frame), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input int v);
    tvalid_stream = 1'b1;
    stream = DW'(v);
    tick();
    tvalid_stream = 1'b0;
  endtask

  task automatic push_sample(input int v, input bit f, input bit l);
    exp_t e;
    e.data = DW'(v);
    e.first = f;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input int start);
    for (int i = 0; i < FL; i++) push_sample(start + i, i == 0, i == FL - 1);
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || busy || tvalid_frame) && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < maxc), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tvalid_stream = 1'b0;
    flush = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    bit found;
    // Reset with the input strobe held high.
    rst_n = 1'b0;
    tvalid_stream = 1'b1;
    stream = 16'hdead;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_tvalid", 32'(tvalid_frame), 32'd0);
    chk("rst_data", 32'(frame_stream), 32'd0);
    chk("rst_first", 32'(frame_first), 32'd0);
    chk("rst_last", 32'(frame_last), 32'd0);
    chk("rst_count", 32'(frame_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tvalid_stream = 1'b0;
    tick();

    // Sparse writes: first frame and its start latency.
    push_frame(1);
    for (int i = 1; i <= 8; i++) begin
      write(i);
      if (i < 8) repeat (3) tick();
    end
    @(negedge clk);
    chk("lat_edge_t", 32'(tvalid_frame), 32'd0);
    tick();
    @(negedge clk);
    chk("lat_edge_t1", 32'(tvalid_frame), 32'd0);
    chk("busy_at_start", 32'(busy), 32'd1);
    tick();
    @(negedge clk);
    chk("lat_edge_t2", 32'(frame_first), 32'd1);
    wait_done("done_sparse1", 100);
    chk("count_sparse1", 32'(frame_count), 32'd1);
    push_frame(5);
    for (int i = 9; i <= 12; i++) begin
      write(i);
      repeat (3) tick();
    end
    wait_done("done_sparse2", 100);
    chk("count_sparse2", 32'(frame_count), 32'd2);
    chk("ovf_sparse", 32'(overflow), 32'd0);

    // Back-to-back writes: three overlapping frames with single-cycle gaps.
    do_reset();
    last_cyc = -1;
    gap_check = 1;
    push_frame(1);
    push_frame(5);
    push_frame(9);
    for (int i = 1; i <= 16; i++) write(i);
    wait_done("done_b2b", 200);
    gap_check = 0;
    chk("count_b2b", 32'(frame_count), 32'd3);
    chk("ovf_b2b", 32'(overflow), 32'd0);

    // Sustained overrun: frames must remain ordered runs of written values.
    do_reset();
    ovf_mode = 1;
    seen_ovf = 0;
    have_prev = 0;
    for (int i = 1; i <= 64; i++) write(i);
    wait_done("done_ovf", 500);
    ovf_mode = 0;
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_frames_seen", 32'(have_prev), 32'd1);

    // Flush with a partial tail, then fresh framing.
    do_reset();
    push_frame(1);
    for (int i = 1; i <= 10; i++) write(i);
    wait_done("done_pre_flush", 200);
    chk("count_pre_flush", 32'(frame_count), 32'd1);
    for (int i = 0; i < FL; i++) push_sample((i < 6) ? 5 + i : 0, i == 0, i == FL - 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_done("done_flush", 200);
    chk("count_flush", 32'(frame_count), 32'd2);
    push_frame(1);
    for (int i = 1; i <= 8; i++) write(i);
    wait_done("done_post_flush", 200);
    chk("count_post_flush", 32'(frame_count), 32'd3);

    // Flush with nothing unseen: no frame, busy pulses.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("empty_flush_busy", 32'(busy), 32'd1);
    repeat (3) tick();
    chk("empty_flush_idle", 32'(busy), 32'd0);
    chk("empty_flush_count", 32'(frame_count), 32'd3);

    // Reset in the middle of a frame.
    push_frame(1);
    for (int i = 1; i <= 8; i++) write(i);
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (frame_first === 1'b1) found = 1;
    end
    chk("midrst_frame_seen", 32'(found), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", 32'(tvalid_frame), 32'd0);
    chk("midrst_count", 32'(frame_count), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("midrst_quiet", 32'(tvalid_frame), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame_overlap_buffer.md
# frame_overlap_buffer

Parametrised single-clock framing stage for the MFCC front end. It sits between pre-emphasis and windowing. Incoming samples are written into a circular buffer. Overlapping frames of FRAME_LEN samples, advancing by HOP_LEN, are replayed as contiguous one-per-cycle bursts. Beyond fixed framing, it adds generic width/length/hop/depth, backlog handling, a sticky overflow flag, a frame counter, and a flush mode that zero-pads the final partial frame.

## Interface
- DATA_W, 32, sample width (raw bits, float32 by default).
- FRAME_LEN, 400, samples per frame (≥2).
- HOP_LEN, 160, frame advance (1..FRAME_LEN).
- ADDR_W, 10, buffer depth DEPTH = 2^ADDR_W. Requires DEPTH ≥ FRAME_LEN + HOP_LEN.
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- tvalid_stream  in  1  sample strobe; at most one sample per cycle.
- stream  in  DATA_W  sample data.
- flush  in  1  one-cycle pulse: emit the final zero-padded frame, then restart framing.
- tvalid_frame  out  1  frame sample valid.
- frame_stream  out  DATA_W  frame sample.
- frame_first  out  1  high with sample 0 of each frame.
- frame_last  out  1  high with sample FRAME_LEN-1 of each frame.
- frame_count  out  16  frames emitted since reset; wraps at 2^16.
- busy  out  1  high while a frame is being emitted or a flush is pending.
- overflow  out  1  sticky: a sample was dropped; cleared only by reset.

## Operation
- Registers:
  - wr_ptr, base (oldest needed sample), cnt (samples stored from base, 0..DEPTH).
  - unseen: samples not yet included in any emitted frame.
  - State: IDLE, EMIT, FLUSH_EMIT.
- Write path:
  - On tvalid_stream with cnt < DEPTH: mem[wr_ptr] <= stream; wr_ptr++ (mod DEPTH); cnt++; unseen++.
  - If cnt == DEPTH: the sample is dropped and overflow <= 1.
  - Writes are accepted in every state, including during emission.
  - Exception: writes are ignored, with no overflow, during FLUSH_EMIT.
- IDLE → EMIT when cnt ≥ FRAME_LEN.
  - Reads base .. base+FRAME_LEN-1 one per cycle.
  - unseen <= 0 at frame start; concurrent writes still increment it.
- Leaving EMIT (cycle of the final read):
  - base += HOP_LEN and cnt -= HOP_LEN, combined with any same-cycle write; frame_count++.
  - Return to IDLE.
  - Base advances only at frame end, so unread samples are never overwritten.
- Flush:
  - flush is latched as a pending flag, sets busy, and is serviced from IDLE only after all backlog frames (cnt ≥ FRAME_LEN) are emitted.
  - If unseen > 0: enter FLUSH_EMIT and emit min(cnt, FRAME_LEN) stored samples from base, then zeros up to FRAME_LEN (frame_first/last as normal); frame_count++.
  - If unseen == 0: no frame is emitted.
  - Either way, then: cnt = 0, unseen = 0, base = wr_ptr, pending cleared. The next frame needs FRAME_LEN fresh samples.
  - A flush arriving while one is already pending is absorbed.
- Reset values: every output 0; all pointers/counters 0; state IDLE. Buffer contents are not cleared.
- Reset mid-frame: outputs drop to 0 asynchronously; the partial frame is abandoned.

## Timing
- Buffer: synchronous read with a registered output.
- Start latency: frame_first / tvalid_frame rise 2 cycles after the edge where IDLE sees cnt ≥ FRAME_LEN. With a write at edge t completing a frame, that is edge t+2.
- Each frame is exactly FRAME_LEN consecutive valid cycles, with no gaps.
- Backlog: consecutive frames are separated by exactly 1 invalid cycle.
- busy: high from the IDLE→EMIT edge through the edge carrying frame_last.
- overflow: asserts on the edge after the dropped write.
- flush and tvalid_stream in the same cycle: the sample is written first, then flush is latched.

## Test plan
All scenarios use DATA_W=16, FRAME_LEN=8, HOP_LEN=4, ADDR_W=4.
- Reset with rst_n low → all outputs 0. Hold tvalid_stream high during reset → nothing stored; after release, 8 new samples are needed before the first frame.
- Write 1..8 at one sample per 4 cycles → frame 1..8 with first on 1 and last on 8; frame_count=1. Write 9..12 → frame 5..12; frame_count=2.
- Write 1..16 on consecutive cycles → frames 1–8, 5–12, 9–16, each 8 contiguous cycles, one gap cycle between frames, overflow stays 0.
- Write 64 samples on consecutive cycles → overflow rises once cnt hits 16 and stays high. Every emitted frame is still a contiguous run of written values (drops show as missing values, never corrupted ones).
- Write 1..10, wait for frame 1..8, pulse flush → frame 5,6,7,8,9,10,0,0; frame_count=2. Then write 1..8 → fresh frame 1..8.
- Pulse flush immediately after a frame whose window already covers all samples (unseen=0) → no frame; busy pulses. Then pull rst_n low during the 4th sample of a frame → tvalid_frame=0 immediately and no further samples.
